image_tile_loader: RTL and testbench
====================================

# image_tile_loader

Sequencer that walks a rectangular tile of the 96x96 8-bit image held in data memory and streams it to the vector pipeline as 16-lane vector beats, one 8-pixel chunk per beat. It drives the memory's word address, uses the memory's same-cycle combinational read (8 consecutive pixels, lanes 8-15 zero), masks partial chunks at the right tile edge, and presents each beat on a valid/ready port. It sits between the vector load/control unit (Start/config) and the image data memory.

## Interface
- IMAGE_WIDTH, 96, pixels per image row
- IMAGE_HEIGHT, 96, image rows
- PIX_SIZE, 8, bits per pixel
- LANES, 8, pixels returned per memory read
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- Start  in  1  start request, sampled only in IDLE
- X0, Y0  in  16 each  tile origin, column and row in pixels
- Cols, Rows  in  16 each  tile width and height in pixels
- Busy  out  1  high from accepted Start until the Done cycle
- Done  out  1  one-cycle completion pulse, normal end or config error
- Err  out  1  config error flag, held until the next accepted Start
- Addr  out  16  memory pixel address
- RD  in  [15:0][15:0]  memory read data, lane i = pixel Addr+i
- VecOut  out  [15:0][15:0]  output vector beat
- VecValid  out  1  VecOut valid
- VecReady  in  1  consumer accepts beat when VecValid and VecReady
- VecX, VecY  out  16 each  image column and row of VecOut lane 0
- VecLast  out  1  marks the final beat of the tile

## Operation
- FSM states: IDLE, CHECK, FETCH, DRAIN, DONE.
- IDLE: Start=1 latches X0, Y0, Cols, Rows, clears Err, sets Busy, goes to CHECK. Start in any other state is ignored.
- CHECK: if Cols==0, Rows==0, X0+Cols>IMAGE_WIDTH or Y0+Rows>IMAGE_HEIGHT, set Err and go to DONE with no memory traffic. Otherwise load cx=X0, cy=Y0 and go to FETCH. Bound sums use 17-bit arithmetic, so there is no wrap.
- Addr = cy*IMAGE_WIDTH + cx, truncated to 16 bits; the maximum is 9215. Addr is 0 outside FETCH.
- FETCH: the output register loads when VecValid==0 or VecReady==1.
  - On load, VecOut lane i = {8'b0, RD[i][7:0]} for i < n, where n = min(LANES, X0+Cols-cx). All other lanes, including 8-15, are 0.
  - VecX=cx, VecY=cy. VecLast=1 when this is the last chunk of the last row.
- Counter advance on each load:
  - cx += LANES. If cx+LANES >= X0+Cols, set cx=X0 and cy += 1.
  - After loading the last beat, go to DRAIN.
- Beats per tile = Rows*ceil(Cols/LANES). Chunks never straddle rows.
- DRAIN: hold the beat until accepted, then go to DONE.
- DONE: pulse Done for one cycle, drop Busy, go to IDLE. Err keeps its value.
- Reset, asynchronous at any point including mid-tile:
  - State goes to IDLE.
  - Busy, Done, Err, VecValid, VecLast and Addr go to 0. VecOut, VecX and VecY go to 0.
  - The in-flight beat is discarded.

## Timing
- Start is sampled at edge E0, giving CHECK. Edge E1 gives FETCH, or DONE on error. Edge E2 captures the first beat, so VecValid is high after E2.
- Throughput is one beat per cycle while VecReady=1. Memory reads are combinational, so the load edge captures the RD for the current Addr.
- Backpressure: while VecValid=1 and VecReady=0, VecOut, VecX, VecY, VecLast and the counters are frozen, and Addr stays stable.
- A beat is accepted only on an edge with VecValid&&VecReady. VecValid drops after acceptance unless a new beat loads on the same edge.
- Done is high in the cycle after the edge that accepts the VecLast beat. In that same cycle Busy=0 and VecValid=0.
- On error, Done and Err are high in the cycle after E1, and Busy=0 in that cycle.
- Start asserted during the Done cycle is ignored. It is accepted on the following cycle, in IDLE.

## Test plan
- X0=0, Y0=0, Cols=16, Rows=2, VecReady=1: Addr sequence is 0, 8, 96, 104. Four consecutive VecValid cycles. VecLast only on the beat at Addr 104. One Done pulse.
- X0=0, Y0=5, Cols=10, Rows=1: beat 1 at Addr 480 has 8 live lanes. Beat 2 at Addr 488 has lanes 0-1 live and lanes 2-15 zero. VecX is 0 then 8.
- X0=90, Y0=0, Cols=8, Rows=1: Err=1 and a Done pulse in the cycle after E1. VecValid never rises and Addr stays 0.
- Two-beat tile with VecReady held low for 3 cycles on beat 1: VecOut and Addr stay stable during the stall, no beat is lost or duplicated, and beat 2 follows the release with no bubble.
- RST_N pulled low after the 2nd beat of a 4-beat tile: all outputs 0 immediately. After release, a new Start runs the full tile from its first address.
- X0=88, Y0=95, Cols=8, Rows=1 (bottom-right corner): a single beat at Addr 9208 with 8 live lanes, VecLast=1, and Err=0.

Source files
------------

// File: rtl/image_tile_loader.sv
// image_tile_loader: walks a rectangular tile of the 96x96 8-bit image in data
// memory and streams it as 16-lane vector beats, one 8-pixel chunk per beat.
// Memory reads are combinational, so the beat register captures RD for the
// current Addr on the same edge that advances the walk counters.
module image_tile_loader #(
  parameter int IMAGE_WIDTH  = 96,
  parameter int IMAGE_HEIGHT = 96,
  parameter int PIX_SIZE     = 8,
  parameter int LANES        = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Start,
  input  logic [15:0]       X0,
  input  logic [15:0]       Y0,
  input  logic [15:0]       Cols,
  input  logic [15:0]       Rows,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [15:0]       Addr,
  input  logic [15:0][15:0] RD,
  output logic [15:0][15:0] VecOut,
  output logic              VecValid,
  input  logic              VecReady,
  output logic [15:0]       VecX,
  output logic [15:0]       VecY,
  output logic              VecLast
);

  localparam logic [15:0] IW16    = 16'(IMAGE_WIDTH);
  localparam logic [16:0] IW17    = 17'(IMAGE_WIDTH);
  localparam logic [16:0] IH17    = 17'(IMAGE_HEIGHT);
  localparam logic [15:0] LANES16 = 16'(LANES);
  localparam logic [16:0] LANES17 = 17'(LANES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nx;

  // Latched tile configuration and walk position
  logic [15:0] x0_r, y0_r, cols_r, rows_r;
  logic [15:0] cx, cy;

  // Tile bounds in 17 bits so the sums never wrap
  logic [16:0] xend, yend, rem;
  logic        cfg_bad, row_end, last_row, last_beat, load, accept;
  logic [15:0] addr_lin;
  logic [15:0] lane_live;

  // Upper pixel bytes and lanes beyond LANES are never forwarded
  logic unused_rd;
  assign unused_rd = ^RD;

  assign xend      = {1'b0, x0_r} + {1'b0, cols_r};
  assign yend      = {1'b0, y0_r} + {1'b0, rows_r};
  assign cfg_bad   = (cols_r == 16'd0) || (rows_r == 16'd0) ||
                     (xend > IW17) || (yend > IH17);
  assign rem       = xend - {1'b0, cx};
  assign row_end   = ({1'b0, cx} + LANES17) >= xend;
  assign last_row  = ({1'b0, cy} + 17'd1) >= yend;
  assign last_beat = row_end && last_row;
  assign addr_lin  = cy * IW16 + cx;
  assign accept    = VecValid && VecReady;
  // The beat register is free when empty or being drained this edge
  assign load      = (state == S_FETCH) && (!VecValid || VecReady);

  // Lane is live when it falls inside the tile's right edge
  always_comb begin
    lane_live = '0;
    for (int i = 0; i < 16; i++) begin
      lane_live[i] = (i < LANES) && (17'(i) < rem);
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (Start) state_nx = S_CHECK;
      S_CHECK: state_nx = cfg_bad ? S_DONE : S_FETCH;
      S_FETCH: if (load && last_beat) state_nx = S_DRAIN;
      S_DRAIN: if (accept) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State-decoded outputs; Addr only driven while fetching
  always_comb begin
    Busy = (state == S_CHECK) || (state == S_FETCH) || (state == S_DRAIN);
    Done = (state == S_DONE);
    Addr = (state == S_FETCH) ? addr_lin : 16'd0;
  end

  // Config latch, error flag and walk counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x0_r   <= '0;
      y0_r   <= '0;
      cols_r <= '0;
      rows_r <= '0;
      cx     <= '0;
      cy     <= '0;
      Err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            x0_r   <= X0;
            y0_r   <= Y0;
            cols_r <= Cols;
            rows_r <= Rows;
            Err    <= 1'b0;
          end
        end
        S_CHECK: begin
          if (cfg_bad) begin
            Err <= 1'b1;
          end else begin
            cx <= x0_r;
            cy <= y0_r;
          end
        end
        S_FETCH: begin
          if (load) begin
            if (row_end) begin
              cx <= x0_r;
              cy <= cy + 16'd1;
            end else begin
              cx <= cx + LANES16;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output beat register: loads a masked chunk, holds it under backpressure
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      VecOut   <= '0;
      VecValid <= 1'b0;
      VecX     <= '0;
      VecY     <= '0;
      VecLast  <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) begin
        VecOut[i] <= lane_live[i] ? 16'(RD[i][PIX_SIZE-1:0]) : 16'd0;
      end
      VecValid <= 1'b1;
      VecX     <= cx;
      VecY     <= cy;
      VecLast  <= last_beat;
    end else if (accept) begin
      VecValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_image_tile_loader.sv
// Testbench for image_tile_loader: random image memory, tile-level reference
// model feeding a scoreboard, monitor checking every accepted beat.
module tb_image_tile_loader;

  logic              CLK;
  logic              RST_N;
  logic              Start;
  logic [15:0]       X0, Y0, Cols, Rows;
  logic              Busy, Done, Err;
  logic [15:0]       Addr;
  logic [15:0][15:0] RD;
  logic [15:0][15:0] VecOut;
  logic              VecValid;
  logic              VecReady;
  logic [15:0]       VecX, VecY;
  logic              VecLast;

  image_tile_loader dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start),
    .X0(X0), .Y0(Y0), .Cols(Cols), .Rows(Rows),
    .Busy(Busy), .Done(Done), .Err(Err), .Addr(Addr), .RD(RD),
    .VecOut(VecOut), .VecValid(VecValid), .VecReady(VecReady),
    .VecX(VecX), .VecY(VecY), .VecLast(VecLast)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0][15:0] v;
    logic [15:0]       x;
    logic [15:0]       y;
    logic              last;
  } beat_t;

  beat_t sb[$];
  int    checks     = 0;
  int    failures   = 0;
  int    beats_seen = 0;
  logic  exp_err    = 1'b0;
  logic  rand_rdy   = 1'b0;

  // Image memory: pixel bytes plus junk in upper bytes and lanes 8-15
  logic [7:0] mem  [0:9231];
  logic [7:0] junk [0:15];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      if (i < 8) RD[i] = {junk[i], mem[int'(Addr) + i]};
      else       RD[i] = {junk[i], junk[15 - i]};
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: expected beats straight from the tile geometry
  task automatic expect_tile(input int x0, input int y0, input int c, input int r);
    beat_t e;
    int n, a;
    exp_err = (c == 0) || (r == 0) || (x0 + c > 96) || (y0 + r > 96);
    if (!exp_err) begin
      for (int row = 0; row < r; row++) begin
        for (int col = 0; col < c; col += 8) begin
          n = (c - col < 8) ? (c - col) : 8;
          a = (y0 + row) * 96 + x0 + col;
          e.v = '0;
          for (int j = 0; j < n; j++) e.v[j] = {8'h00, mem[a + j]};
          e.x    = 16'(x0 + col);
          e.y    = 16'(y0 + row);
          e.last = (row == r - 1) && (col + 8 >= c);
          sb.push_back(e);
        end
      end
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after E0 (CHECK)
  task automatic start_tile(input int x0, input int y0, input int c, input int r);
    expect_tile(x0, y0, c, r);
    X0 = 16'(x0); Y0 = 16'(y0); Cols = 16'(c); Rows = 16'(r);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    chk("busy_after_start", 256'(Busy), 256'(1));
  endtask

  // Waits for the Done pulse and checks the completion cycle
  task automatic wait_done(input int budget);
    int n = 0;
    while (!Done && n < budget) begin
      @(negedge CLK);
      if (rand_rdy) VecReady = 1'($urandom_range(0, 1));
      n++;
    end
    checks++;
    if (!Done) begin
      failures++;
      $display("FAIL done_timeout actual=0 required=1 after %0d cycles", n);
    end else begin
      chk("done_err",   256'(Err),      256'(exp_err));
      chk("done_busy",  256'(Busy),     256'(0));
      chk("done_valid", 256'(VecValid), 256'(0));
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL beats_missing actual=%0d required=0", sb.size());
      end
    end
    sb.delete();
  endtask

  task automatic finish_tile(input int budget);
    wait_done(budget);
    @(negedge CLK);
  endtask

  // Monitor: every accepted beat is compared against the scoreboard head
  initial begin
    beat_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (RST_N && VecValid && VecReady) begin
        beats_seen++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=x%0d,y%0d required=none", VecX, VecY);
        end else begin
          e = sb.pop_front();
          chk("beat_data", 256'(VecOut), 256'(e.v));
          chk("beat_x",    256'(VecX),   256'(e.x));
          chk("beat_y",    256'(VecY),   256'(e.y));
          chk("beat_last", 256'(VecLast), 256'(e.last));
        end
      end
    end
  end

  initial begin
    logic [255:0] sv_v;
    logic [15:0]  sv_a;
    int base, n, x0, y0, c, r;

    for (int i = 0; i < 9232; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) junk[i] = 8'($urandom_range(1, 255));
    RST_N = 1'b0; Start = 1'b0; VecReady = 1'b1;
    X0 = '0; Y0 = '0; Cols = '0; Rows = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_busy",  256'(Busy),     256'(0));
    chk("rst_done",  256'(Done),     256'(0));
    chk("rst_err",   256'(Err),      256'(0));
    chk("rst_valid", 256'(VecValid), 256'(0));
    chk("rst_addr",  256'(Addr),     256'(0));
    RST_N = 1'b1;
    @(negedge CLK);

    // 16x2 tile at origin: address sequence and first-beat latency
    start_tile(0, 0, 16, 2);
    @(negedge CLK);
    chk("t1_addr0",  256'(Addr), 256'(0));
    chk("t1_lat_v0", 256'(VecValid), 256'(0));
    @(negedge CLK);
    chk("t1_addr8",  256'(Addr), 256'(8));
    chk("t1_lat_v1", 256'(VecValid), 256'(1));
    @(negedge CLK);
    chk("t1_addr96", 256'(Addr), 256'(96));
    @(negedge CLK);
    chk("t1_addr104", 256'(Addr), 256'(104));
    finish_tile(50);

    // Partial right-edge chunk
    start_tile(0, 5, 10, 1);
    @(negedge CLK);
    chk("t2_addr480", 256'(Addr), 256'(480));
    @(negedge CLK);
    chk("t2_addr488", 256'(Addr), 256'(488));
    finish_tile(50);

    // Config error: Done and Err one cycle after E1, no traffic
    start_tile(90, 0, 8, 1);
    chk("err_addr_chk", 256'(Addr), 256'(0));
    @(negedge CLK);
    chk("err_done", 256'(Done), 256'(1));
    chk("err_flag", 256'(Err),  256'(1));
    chk("err_busy", 256'(Busy), 256'(0));
    chk("err_addr", 256'(Addr), 256'(0));
    finish_tile(5);

    // Bottom-right corner single beat; Err cleared by new Start
    start_tile(88, 95, 8, 1);
    chk("corner_err_clr", 256'(Err), 256'(0));
    @(negedge CLK);
    chk("corner_addr", 256'(Addr), 256'(9208));
    finish_tile(50);

    // Backpressure: 3 stalled cycles on beat 1, then no bubble
    VecReady = 1'b0;
    start_tile(8, 3, 16, 1);
    @(negedge CLK);
    chk("stall_v0", 256'(VecValid), 256'(0));
    @(negedge CLK);
    chk("stall_v1", 256'(VecValid), 256'(1));
    sv_v = VecOut;
    sv_a = Addr;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("stall_vec",   256'(VecOut),   sv_v);
      chk("stall_addr",  256'(Addr),     256'(sv_a));
      chk("stall_valid", 256'(VecValid), 256'(1));
    end
    VecReady = 1'b1;
    @(negedge CLK);
    chk("stall_nobubble_v", 256'(VecValid), 256'(1));
    chk("stall_nobubble_x", 256'(VecX),     256'(16));
    finish_tile(50);

    // Start during the Done cycle is ignored, accepted one cycle later
    start_tile(16, 40, 8, 1);
    wait_done(50);
    expect_tile(24, 41, 8, 2);
    X0 = 16'd24; Y0 = 16'd41; Cols = 16'd8; Rows = 16'd2;
    Start = 1'b1;
    @(negedge CLK);
    chk("done_start_ignored", 256'(Busy), 256'(0));
    @(negedge CLK);
    chk("idle_start_taken", 256'(Busy), 256'(1));
    Start = 1'b0;
    finish_tile(50);

    // Asynchronous reset after the 2nd beat of a 4-beat tile
    base = beats_seen;
    start_tile(0, 10, 16, 2);
    n = 0;
    while (beats_seen < base + 2 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_mid_reach", 256'(beats_seen - base), 256'(2));
    VecReady = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("amid_busy",  256'(Busy),     256'(0));
    chk("amid_done",  256'(Done),     256'(0));
    chk("amid_err",   256'(Err),      256'(0));
    chk("amid_valid", 256'(VecValid), 256'(0));
    chk("amid_last",  256'(VecLast),  256'(0));
    chk("amid_addr",  256'(Addr),     256'(0));
    chk("amid_vec",   256'(VecOut),   256'(0));
    chk("amid_xy",    256'({VecX, VecY}), 256'(0));
    sb.delete();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    VecReady = 1'b1;
    @(negedge CLK);
    start_tile(0, 10, 16, 2);
    @(negedge CLK);
    chk("rerun_addr_first", 256'(Addr), 256'(960));
    finish_tile(50);

    // Randomized tiles with random backpressure, some invalid configs
    rand_rdy = 1'b1;
    for (int t = 0; t < 25; t++) begin
      c  = $urandom_range(1, 24);
      r  = $urandom_range(1, 4);
      x0 = $urandom_range(0, 96 - c);
      y0 = $urandom_range(0, 96 - r);
      case ($urandom_range(0, 7))
        0: c  = 0;
        1: r  = 0;
        2: x0 = $urandom_range(97 - c, 300);
        3: y0 = $urandom_range(97 - r, 300);
        default: ;
      endcase
      start_tile(x0, y0, c, r);
      finish_tile(1000);
    end
    rand_rdy = 1'b0;
    VecReady = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
